// File: rtl/reg_fifo_if.sv
// Valid/ready handshake bundle for reg_fifo: producer side, consumer side and
// occupancy status. The slave modport is the FIFO's view of the bundle.
interface reg_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, explicit
// occupancy counter and almost-full flag for producer throttling.
module reg_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_fifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  // Handshake flags come from the registered count only, so neither ready nor
  // valid has a combinational path from the opposite side.
  assign bus.in_ready    = (cnt != CW'(DEPTH));
  assign bus.out_valid   = (cnt != '0);
  assign bus.out_data    = mem[rp];
  assign bus.count       = cnt;
  assign bus.almost_full = (cnt >= CW'(AF_LEVEL));

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp] <= bus.in_data;
        wp      <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo: reset state, fill/drain vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_reg_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  reg_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] q[$];

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    int           cnt;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
    logic         af;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: a bounded queue; decisions use the state before the edge.
  task automatic model_edge(input logic iv, input logic [W-1:0] d, input logic ordy);
    bit full, empty;
    full  = (q.size() == D);
    empty = (q.size() == 0);
    if (ordy && !empty) void'(q.pop_front());
    if (iv && !full) q.push_back(d);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(q.size() != D));
    chk({tag, "_almost_full"}, 32'(bus.almost_full), 32'(q.size() >= AF));
    if (q.size() != 0) chk({tag, "_out_data"}, 32'(bus.out_data), 32'(q[0]));
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    model_edge(iv, d, ordy);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input int cnt, input logic ov, input logic [W-1:0] od,
                              input logic ir, input logic af);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.cnt = cnt;
    v.ov = ov; v.od = od; v.ir = ir; v.af = af;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         hold;
    logic         iv, ordy;
    logic [W-1:0] d;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_almost_full", 32'(bus.almost_full), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);

    // Fill to full, refuse a fifth word, full with both sides active, then drain.
    vecs.push_back(mk(1, 8'h11, 0, 1, 1, 8'h11, 1, 0));
    vecs.push_back(mk(1, 8'h22, 0, 2, 1, 8'h11, 1, 0));
    vecs.push_back(mk(1, 8'h33, 0, 3, 1, 8'h11, 1, 1));
    vecs.push_back(mk(1, 8'h44, 0, 4, 1, 8'h11, 0, 1));
    vecs.push_back(mk(1, 8'h55, 0, 4, 1, 8'h11, 0, 1));
    vecs.push_back(mk(1, 8'h55, 1, 3, 1, 8'h22, 1, 1));
    vecs.push_back(mk(1, 8'h55, 0, 4, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3, 1, 8'h33, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 2, 1, 8'h44, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].ir));
      chk($sformatf("vec%0d_almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
      if (vecs[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].od));
    end

    // Empty with push and out_ready: no bypass, word appears after the edge.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b1;
    #1;
    chk("empty_push_pre_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    model_edge(1'b1, 8'h77, 1'b1);
    #1;
    chk("empty_push_count", 32'(bus.count), 1);
    chk("empty_push_out_valid", 32'(bus.out_valid), 1);
    chk("empty_push_out_data", 32'(bus.out_data), 32'h77);
    cycle(0, 8'h00, 1);
    chk("empty_push_drained", 32'(bus.count), 0);

    // Streaming through the pointer wrap: count stays 1, order preserved.
    for (int k = 0; k < 10; k++) begin
      cycle(1, W'(k), 1);
      chk($sformatf("wrap%0d_count", k), 32'(bus.count), 1);
      chk($sformatf("wrap%0d_out_data", k), 32'(bus.out_data), 32'(k));
    end
    cycle(0, 8'h00, 1);
    chk("wrap_end_count", 32'(bus.count), 0);
    chk("wrap_end_out_valid", 32'(bus.out_valid), 0);

    // Asynchronous reset between edges with three words stored.
    cycle(1, 8'h01, 0);
    cycle(1, 8'h02, 0);
    cycle(1, 8'h03, 0);
    chk("midrst_pre_count", 32'(bus.count), 3);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_almost_full", 32'(bus.almost_full), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    #1;
    rst_n = 1'b1;
    cycle(1, 8'hAA, 0);
    chk("midrst_first_out_data", 32'(bus.out_data), 32'hAA);
    chk("midrst_first_count", 32'(bus.count), 1);
    cycle(0, 8'h00, 1);
    chk("midrst_drained", 32'(bus.count), 0);

    // Randomized traffic against the queue model, biased to visit full and empty.
    hold = 1'b0;
    d    = '0;
    iv   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        iv = (n < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        d  = W'($urandom);
      end
      ordy = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
      chk($sformatf("rnd%0d_pre_in_ready", n), 32'(bus.in_ready), 32'(q.size() != D));
      hold = iv && (q.size() == D);
      @(posedge clk);
      model_edge(iv, d, ordy);
      #1;
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_fifo.md
# reg_fifo

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly upstream of the pipeline register stages and buffers producer data so the downstream register is written only when the downstream side accepts a word. It also reports occupancy and an almost-full flag for producer-side throttling.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `AF_LEVEL`, default DEPTH-1: `almost_full` threshold, 1..DEPTH.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: producer presents `in_data`.
- `in_data`  input  WIDTH: write data.
- `in_ready`  output  1: FIFO can accept a word this cycle.
- `out_valid`  output  1: `out_data` holds the oldest stored word.
- `out_data`  output  WIDTH: head-of-queue data.
- `out_ready`  input  1: consumer takes the head word this cycle.
- `count`  output  $clog2(DEPTH)+1: current number of stored words, 0..DEPTH.
- `almost_full`  output  1: high when `count >= AF_LEVEL`.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits wide, wrapping modulo DEPTH. Occupancy is held in `count`, not derived from the pointers.
- Push: `push = in_valid & in_ready`. It writes `in_data` at `wp` and increments `wp`.
- Pop: `pop = out_valid & out_ready`. It increments `rp`.
- `count` update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `in_ready = (count != DEPTH)`. It depends on registered state only; there is no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- `out_data = mem[rp]`, read combinationally; it is stable while `out_valid & !out_ready`.
- Full with `out_ready` high: `in_ready` stays 0 that cycle. The pop happens and the push does not (no full-bypass). Next cycle `count = DEPTH-1` and `in_ready = 1`.
- Empty with `in_valid` high: the push happens. `out_valid` stays 0 that cycle (no empty-bypass) and rises on the next cycle.
- Simultaneous push and pop with `0 < count < DEPTH`: both take effect, `count` is unchanged, and both pointers advance.
- Data is never overwritten or dropped. Ordering is strict FIFO.
- Protocol rules:
  - Producer must hold `in_data` stable while `in_valid & !in_ready`.
  - Consumer must not depend on `out_data` when `out_valid = 0`.
  - Pointer wrap from DEPTH-1 to 0 is transparent.

## Timing
- Reset (`rst_n` low, asynchronous assert):
  - `wp = rp = 0`, `count = 0`.
  - Outputs: `out_valid = 0`, `in_ready = 1`, `almost_full = 0` (given AF_LEVEL ≥ 1), `out_data = 0`. All memory entries are cleared to 0.
- Reset assertion mid-operation discards all stored words immediately, without waiting for a clock edge.
- Reset deassertion is taken synchronously in the design context. The first push can occur on the first rising edge with `rst_n` high.
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on `out_data` with `out_valid` high after edge N.
- Throughput: one push and one pop per cycle sustained while `0 < count < DEPTH`.
- `count`, `almost_full`, `in_ready` and `out_valid` all change only after clock edges or on reset assertion.

## Test plan
- Reset state: hold `rst_n = 0`, then release → `count = 0`, `out_valid = 0`, `in_ready = 1`, `almost_full = 0`, `out_data = 0`.
- Fill/drain, DEPTH = 4:
  - Push 0x11, 0x22, 0x33, 0x44 with `out_ready = 0` → `count` goes 1, 2, 3, 4; `almost_full` rises at `count = 3`; `in_ready = 0` at 4.
  - A fifth `in_valid` is not accepted.
  - Then set `out_ready = 1` → outputs 0x11, 0x22, 0x33, 0x44 in order, then `out_valid = 0`.
- Full with simultaneous `in_valid` and `out_ready`: pop 0x11, no push that cycle, `count = 3`. The next cycle's push is accepted and `count = 4` again.
- Wrap-around: 10 words 0x00..0x09 streamed with `in_valid = out_ready = 1` from empty → first output one cycle after first push; `count` holds 1 throughout; output order 0x00..0x09; pointers wrap twice.
- Empty with push and `out_ready = 1`: `out_valid = 0` that cycle, no pop; `count = 1`, `out_valid = 1` after the edge.
- Mid-operation reset: with `count = 3`, pulse `rst_n` low between clock edges → `out_valid`, `count` and `almost_full` drop to 0 immediately. The next pushed word 0xAA is the first popped.
